// File: rtl/mac_seq_pkg.sv
// Shared definitions for the mac_seq_ctrl job sequencer.
//   state_t     : sequencer FSM states
//   DEF_*       : default widths and latencies
//   drain_cyc() : number of drain cycles needed for a given MAC latency
package mac_seq_pkg;

   localparam int unsigned DEF_DATA_W  = 8;
   localparam int unsigned DEF_ACC_W   = 22;
   localparam int unsigned DEF_LEN_W   = 8;
   localparam int unsigned DEF_MAC_LAT = 2;
   localparam int unsigned DEF_TMO_CYC = 64;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      HOLD   = 3'd4
   } state_t;

   // One cycle for the operand register, then the MAC pipeline itself.
   function automatic int unsigned drain_cyc(input int unsigned mac_lat);
      return mac_lat + 1;
   endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Bus bundle between the job/operand source, mac_seq_ctrl and top_mac.
//   job    : start, len, busy
//   stream : in_valid, in_ready, in_a, in_b
//   mac    : mac_clr, mac_a, mac_b, mac_y
//   result : out_valid, out_ready, res, err
// slave modport is the controller view; master is the environment view.
interface mac_seq_ctrl_if
   import mac_seq_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ACC_W  = DEF_ACC_W,
   parameter int unsigned LEN_W  = DEF_LEN_W
);
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              mac_clr;
   logic [DATA_W-1:0] mac_a;
   logic [DATA_W-1:0] mac_b;
   logic [ACC_W-1:0]  mac_y;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  res;
   logic              err;

   modport slave (
      input  start, len, in_valid, in_a, in_b, mac_y, out_ready,
      output busy, in_ready, mac_clr, mac_a, mac_b, out_valid, res, err
   );

   modport master (
      output start, len, in_valid, in_a, in_b, mac_y, out_ready,
      input  busy, in_ready, mac_clr, mac_a, mac_b, out_valid, res, err
   );
endinterface

// File: rtl/mac_seq_cnt.sv
// Loadable down-counter with zero flag.
//   clk, rst   : clock, synchronous active-high reset
//   i_load     : load i_load_val (has priority over i_dec)
//   i_load_val : value to load
//   i_dec      : decrement by one, saturating at zero
//   o_zero_c   : count is zero (combinational from the count register)
module mac_seq_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero_c
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the top_mac multiply-accumulate datapath.
// Accepts a job length, clears the MAC, streams len operand pairs into it,
// waits for the MAC pipeline to drain and presents the dot product on a
// valid/ready result port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mac_seq_ctrl_if.slave (job, stream, mac and result signals)
// Optional feature macro: MAC_SEQ_TIMEOUT_EN (stall timeout abort with err).
module mac_seq_ctrl
   import mac_seq_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned ACC_W   = DEF_ACC_W,
   parameter int unsigned LEN_W   = DEF_LEN_W,
`ifdef MAC_SEQ_TIMEOUT_EN
   parameter int unsigned TMO_CYC = DEF_TMO_CYC,
`endif
   parameter int unsigned MAC_LAT = DEF_MAC_LAT
) (
   input logic           clk,
   input logic           rst,
   mac_seq_ctrl_if.slave bus
);

   localparam int unsigned DRAIN_CYC = drain_cyc(MAC_LAT);
   localparam int unsigned DRN_W     = $clog2(DRAIN_CYC + 1);

   state_t            r_state;
   logic [LEN_W-1:0]  r_len;
   logic              r_busy;
   logic              r_in_ready;
   logic              r_mac_clr;
   logic [DATA_W-1:0] r_mac_a;
   logic [DATA_W-1:0] r_mac_b;
   logic              r_out_valid;
   logic [ACC_W-1:0]  r_res;

   logic              w_beat;
   logic              w_beat_zero;
   logic              w_drain_zero;
   logic [LEN_W-1:0]  w_beat_init;

   assign w_beat      = bus.in_valid & r_in_ready;
   assign w_beat_init = r_len - LEN_W'(1);

   // Beat counter: loaded with len-1 in CLEAR, zero marks the last beat.
   mac_seq_cnt #(.W(LEN_W)) u_beat_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (r_state == CLEAR),
      .i_load_val (w_beat_init),
      .i_dec      (w_beat),
      .o_zero_c   (w_beat_zero)
   );

   // Drain counter: preloaded outside DRAIN, zero marks the capture cycle.
   mac_seq_cnt #(.W(DRN_W)) u_drain_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (r_state != DRAIN),
      .i_load_val (DRN_W'(DRAIN_CYC - 1)),
      .i_dec      (r_state == DRAIN),
      .o_zero_c   (w_drain_zero)
   );

`ifdef MAC_SEQ_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);

   logic r_err;
   logic w_stall_zero;

   // Stall timer: reloaded on every beat and outside STREAM.
   mac_seq_cnt #(.W(TMO_W)) u_stall_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     ((r_state != STREAM) || w_beat),
      .i_load_val (TMO_W'(TMO_CYC - 1)),
      .i_dec      ((r_state == STREAM) && !w_beat),
      .o_zero_c   (w_stall_zero)
   );
`endif

   // Sequencer FSM with its registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_len       <= '0;
         r_busy      <= 1'b0;
         r_in_ready  <= 1'b0;
         r_mac_clr   <= 1'b0;
         r_mac_a     <= '0;
         r_mac_b     <= '0;
         r_out_valid <= 1'b0;
         r_res       <= '0;
`ifdef MAC_SEQ_TIMEOUT_EN
         r_err       <= 1'b0;
`endif
      end else begin
         // Idle MAC inputs contribute 0*0 and the clear is a single pulse.
         r_mac_clr <= 1'b0;
         r_mac_a   <= '0;
         r_mac_b   <= '0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_len     <= bus.len;
                  r_busy    <= 1'b1;
                  r_mac_clr <= 1'b1;
                  r_state   <= CLEAR;
               end
            end
            CLEAR: begin
               if (r_len == '0) begin
                  r_state <= DRAIN;
               end else begin
                  r_in_ready <= 1'b1;
                  r_state    <= STREAM;
               end
            end
            STREAM: begin
               if (w_beat) begin
                  r_mac_a <= bus.in_a;
                  r_mac_b <= bus.in_b;
                  if (w_beat_zero) begin
                     r_in_ready <= 1'b0;
                     r_state    <= DRAIN;
                  end
               end
`ifdef MAC_SEQ_TIMEOUT_EN
               else if (w_stall_zero) begin
                  r_in_ready  <= 1'b0;
                  r_mac_clr   <= 1'b1;
                  r_err       <= 1'b1;
                  r_res       <= '0;
                  r_out_valid <= 1'b1;
                  r_state     <= HOLD;
               end
`endif
            end
            DRAIN: begin
               if (w_drain_zero) begin
                  r_res       <= bus.mac_y;
                  r_out_valid <= 1'b1;
                  r_state     <= HOLD;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
                  r_err       <= 1'b0;
`endif
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.in_ready  = r_in_ready;
   assign bus.mac_clr   = r_mac_clr;
   assign bus.mac_a     = r_mac_a;
   assign bus.mac_b     = r_mac_b;
   assign bus.out_valid = r_out_valid;
   assign bus.res       = r_res;
`ifdef MAC_SEQ_TIMEOUT_EN
   assign bus.err       = r_err;
`else
   assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed testbench for mac_seq_ctrl with a behavioural top_mac model
// (operand register stage plus accumulator, 2-cycle latency).
module tb_mac_seq_ctrl;
   import mac_seq_pkg::*;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   mac_seq_ctrl_if bus ();

   mac_seq_ctrl u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // top_mac model: a/b registered, then accumulated; mac_clr is its reset.
   logic [7:0]  m_a_q;
   logic [7:0]  m_b_q;
   logic [15:0] m_prod;
   logic [21:0] m_acc;

   assign m_prod    = m_a_q * m_b_q;
   assign bus.mac_y = m_acc;

   always @(posedge clk) begin
      if (rst || bus.mac_clr) begin
         m_a_q <= '0;
         m_b_q <= '0;
         m_acc <= '0;
      end else begin
         m_a_q <= bus.mac_a;
         m_b_q <= bus.mac_b;
         m_acc <= m_acc + {6'd0, m_prod};
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic start_job(input logic [7:0] l);
      bus.start = 1'b1;
      bus.len   = l;
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_on_start", 32'(bus.busy), 1);
      chk("clr_in_clear", 32'(bus.mac_clr), 1);
      chk("mac_a_in_clear", 32'(bus.mac_a), 0);
   endtask

   task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int gap);
      int n;
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("in_ready_timeout", 0, 1);
      else @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!bus.out_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 200) chk("out_valid_timeout", 0, 1);
   endtask

   // Waits for a result, holds out_ready low for 'hold' cycles, then completes it.
   task automatic take_result(input string tag, input logic [21:0] exp, input int hold);
      int cyc;
      bus.out_ready = (hold == 0);
      wait_valid(cyc);
      chk(tag, 32'(bus.res), 32'(exp));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("valid_held", 32'(bus.out_valid), 1);
         chk("res_stable", 32'(bus.res), 32'(exp));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("valid_drop", 32'(bus.out_valid), 0);
      chk("busy_drop", 32'(bus.busy), 0);
      bus.out_ready = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
      chk({tag, "_mac_clr"}, 32'(bus.mac_clr), 0);
      chk({tag, "_mac_a"}, 32'(bus.mac_a), 0);
      chk({tag, "_mac_b"}, 32'(bus.mac_b), 0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
      chk({tag, "_res"}, 32'(bus.res), 0);
      chk({tag, "_err"}, 32'(bus.err), 0);
   endtask

   initial begin
      int cyc;
      n_chk         = 0;
      n_err         = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      do_reset();
      chk_idle_outputs("reset");

      // T1: back-to-back pairs, out_ready high -> 9+16+21+24+25
      bus.out_ready = 1'b1;
      start_job(8'd5);
      send_pair(8'd1, 8'd9, 0);
      send_pair(8'd2, 8'd8, 0);
      send_pair(8'd3, 8'd7, 0);
      send_pair(8'd4, 8'd6, 0);
      send_pair(8'd5, 8'd5, 0);
      chk("t1_in_ready_after_last", 32'(bus.in_ready), 0);
      take_result("t1_res", 22'd95, 0);

      // T2: empty job; CLEAR, 3 DRAIN cycles, capture; start ignored on HOLD exit
      bus.out_ready = 1'b0;
      start_job(8'd0);
      chk("t2_in_ready", 32'(bus.in_ready), 0);
      wait_valid(cyc);
      chk("t2_latency", 32'(cyc), 4);
      chk("t2_res", 32'(bus.res), 0);
      bus.out_ready = 1'b1;
      bus.start     = 1'b1;
      bus.len       = 8'd0;
      @(negedge clk);
      chk("t2_start_in_hold_exit", 32'(bus.busy), 0);
      chk("t2_valid_drop", 32'(bus.out_valid), 0);
      @(negedge clk);
      bus.start = 1'b0;
      chk("t2_start_next_cycle", 32'(bus.busy), 1);
      take_result("t2b_res", 22'd0, 0);

      // T3: gaps of 2 cycles, out_ready low for 3 cycles -> 100+60+49
      start_job(8'd3);
      send_pair(8'd10, 8'd10, 2);
      bus.start = 1'b1;
      bus.len   = 8'd99;
      send_pair(8'd20, 8'd3, 2);
      bus.start = 1'b0;
      send_pair(8'd7, 8'd7, 2);
      take_result("t3_res", 22'd209, 3);

      // T4: reset mid-job, then a clean len=2 job -> 4+9
      start_job(8'd4);
      send_pair(8'd50, 8'd50, 0);
      send_pair(8'd60, 8'd60, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_idle_outputs("t4_rst");
      start_job(8'd2);
      send_pair(8'd2, 8'd2, 0);
      send_pair(8'd3, 8'd3, 0);
      take_result("t4_res", 22'd13, 0);

      // T5: 65 x 255*255 = 4226625, wraps modulo 2**22 to 32321
      start_job(8'd65);
      for (int i = 0; i < 65; i++) send_pair(8'd255, 8'd255, 0);
      take_result("t5_wrap", 22'd32321, 0);

      // T6: stream stalls after one beat
      start_job(8'd4);
      send_pair(8'd1, 8'd1, 0);
`ifdef MAC_SEQ_TIMEOUT_EN
      wait_valid(cyc);
      chk("t6_tmo_latency", 32'(cyc), 64);
      chk("t6_err", 32'(bus.err), 1);
      chk("t6_res", 32'(bus.res), 0);
      chk("t6_clr_pulse", 32'(bus.mac_clr), 1);
      chk("t6_in_ready", 32'(bus.in_ready), 0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("t6_err_clear", 32'(bus.err), 0);
      chk("t6_valid_clear", 32'(bus.out_valid), 0);
      chk("t6_clr_single", 32'(bus.mac_clr), 0);
      bus.out_ready = 1'b0;
`else
      repeat (100) @(negedge clk);
      chk("t6_still_streaming", 32'(bus.in_ready), 1);
      chk("t6_no_result", 32'(bus.out_valid), 0);
      chk("t6_busy", 32'(bus.busy), 1);
      chk("t6_err_tied", 32'(bus.err), 0);
      do_reset();
`endif
      chk_idle_outputs("end");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
